// File: rtl/vram_bus_arbiter.sv
// Arbiter for the shared 4096 x 16 video/program RAM. The CPU owns the bus by
// default; the display fetch engine takes it over with the hold/hold_ack burst
// handshake. A burst longer than MAX_HOLD cycles is cut off, flagged in a sticky
// overrun bit, and no new grant is given until the display drops hold.
module vram_bus_arbiter #(
    parameter int MAX_HOLD = 64,
    parameter int AW       = 12,
    parameter int DW       = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    // display fetch engine
    input  logic          hold,
    output logic          hold_ack,
    input  logic [AW-1:0] disp_addr,
    output logic [DW-1:0] disp_data,
    // CPU port
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_ready,
    // RAM port
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    // status
    output logic          hold_overrun
);

    localparam int            CW      = $clog2(MAX_HOLD + 1);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_HOLD);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CPU_ACC = 2'd1,
        GRANT   = 2'd2
    } state_t;

    state_t        state_reg;
    logic [CW-1:0] cnt_reg;
    logic [CW-1:0] cnt_next;
    logic          block_reg;
    logic          hold_ack_reg;
    logic          cpu_ready_reg;
    logic [DW-1:0] cpu_rdata_reg;
    logic          overrun_reg;

    // Saturating increment of the grant-length counter
    always_comb begin
        cnt_next = (cnt_reg == MAX_CNT) ? cnt_reg : cnt_reg + 1'b1;
    end

    // Control FSM; hold_ack is registered as "next state is GRANT"
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            block_reg     <= 1'b0;
            hold_ack_reg  <= 1'b0;
            cpu_ready_reg <= 1'b0;
            cpu_rdata_reg <= '0;
            overrun_reg   <= 1'b0;
        end else begin
            cpu_ready_reg <= 1'b0;
            hold_ack_reg  <= 1'b0;
            // The block is lifted on the first cycle the display lets go of hold
            if (!hold) begin
                block_reg <= 1'b0;
            end
            case (state_reg)
                IDLE: begin
                    if (hold && !block_reg) begin
                        state_reg    <= GRANT;
                        hold_ack_reg <= 1'b1;
                        cnt_reg      <= '0;
                    end else if (cpu_req) begin
                        state_reg <= CPU_ACC;
                    end
                end
                CPU_ACC: begin
                    // cpu_addr was already on the RAM in the preceding IDLE
                    // cycle, so mem_rdata now holds the addressed word. A
                    // pending hold is served only after returning to IDLE.
                    state_reg     <= IDLE;
                    cpu_ready_reg <= 1'b1;
                    cpu_rdata_reg <= mem_rdata;
                end
                GRANT: begin
                    if (!hold) begin
                        state_reg <= IDLE;
                    end else if (cnt_next >= MAX_CNT) begin
                        state_reg   <= IDLE;
                        cnt_reg     <= cnt_next;
                        overrun_reg <= 1'b1;
                        block_reg   <= 1'b1;
                    end else begin
                        cnt_reg      <= cnt_next;
                        hold_ack_reg <= 1'b1;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    // RAM port steering: CPU address by default, display address while granted
    always_comb begin
        mem_addr  = cpu_addr;
        mem_we    = 1'b0;
        mem_wdata = cpu_wdata;
        case (state_reg)
            CPU_ACC: mem_we   = cpu_we;
            GRANT:   mem_addr = disp_addr;
            default: ;
        endcase
    end

    assign disp_data    = mem_rdata;
    assign hold_ack     = hold_ack_reg;
    assign cpu_ready    = cpu_ready_reg;
    assign cpu_rdata    = cpu_rdata_reg;
    assign hold_overrun = overrun_reg;

endmodule

// File: doc/vram_bus_arbiter.md
# vram_bus_arbiter

Owns the shared 4096 x 16 video/program RAM and grants it either to the CPU or to the display fetch engine. The fetch engine requests the bus with `hold`, waits for `hold_ack`, and then drives word addresses while sampling returned data every cycle. This block is the responder end of that hold/hold_ack burst protocol. It stalls the CPU while the display owns the bus and flags display bursts that run too long.

## Interface
- `MAX_HOLD`, 64: maximum consecutive cycles `hold_ack` may stay high before a forced release.
- `AW`, 12: RAM word-address width.
- `DW`, 16: RAM data width.

- `clk` in 1: system clock; all state on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `hold` in 1: bus request from the display fetch engine (level).
- `hold_ack` out 1: bus granted to the display (registered).
- `disp_addr` in AW: display read address, valid while `hold_ack`=1.
- `disp_data` out DW: read data to the display, equal to `mem_rdata` (pass-through).
- `cpu_req` in 1: CPU access request; held until `cpu_ready`.
- `cpu_we` in 1: 1 = write, 0 = read.
- `cpu_addr` in AW: CPU word address.
- `cpu_wdata` in DW: CPU write data.
- `cpu_rdata` out DW: CPU read data, valid when `cpu_ready`=1 (registered).
- `cpu_ready` out 1: one-cycle completion pulse (registered).
- `mem_addr` out AW: RAM address.
- `mem_we` out 1: RAM write enable.
- `mem_wdata` out DW: RAM write data.
- `mem_rdata` in DW: RAM read data, one-cycle synchronous latency.
- `hold_overrun` out 1: sticky flag, set on forced release; cleared only by reset.

## Operation
- **States:**
  - IDLE: CPU owns the bus, no access in flight.
  - CPU_ACC: CPU address presented.
  - GRANT: display owns the bus.
- **IDLE:**
  - `hold`=1 and not blocked → GRANT. `hold` wins over a simultaneous `cpu_req`.
  - Otherwise `cpu_req`=1 → CPU_ACC.
  - Otherwise stay.
- **CPU_ACC:**
  - `mem_addr`=`cpu_addr`, `mem_we`=`cpu_we`, `mem_wdata`=`cpu_wdata`.
  - Next edge: `cpu_ready`=1, `cpu_rdata`=`mem_rdata`, → IDLE.
  - A `hold` arriving during CPU_ACC waits; the in-flight access always completes.
- **GRANT:**
  - `mem_addr`=`disp_addr`, `mem_we`=0. CPU requests are not accepted and `cpu_ready` stays 0.
  - `hold`=0 → IDLE.
  - Grant counter reaches `MAX_HOLD` → IDLE, set `hold_overrun`, set the block flag.
- **Outside CPU_ACC and GRANT:** `mem_addr`=`cpu_addr`, `mem_we`=0.
- **Block flag:** a set flag suppresses re-grant. It clears on the first cycle `hold`=0. The CPU may use the bus while blocked.
- **Grant counter:**
  - Width clog2(`MAX_HOLD`+1).
  - Zeroed on entry to GRANT; increments each GRANT cycle; saturates, never wraps.
- **Outputs:** `hold_ack` = registered (next state == GRANT). `cpu_ready` is never 1 while `hold_ack`=1.
- **Back-to-back CPU access:** a `cpu_req` still high in the cycle after `cpu_ready` is a new access.

## Timing
- **Reset** (async assert, sync release):
  - State IDLE.
  - `hold_ack`, `cpu_ready`, `hold_overrun` = 0.
  - `cpu_rdata` = 0.
  - Counter = 0, block flag = 0.
  - Asserting `rst_n` mid-GRANT drops `hold_ack` immediately, without waiting for `clk`.
- **Grant latency** (`hold` rising edge sampled at edge N):
  - From IDLE: `hold_ack`=1 after edge N.
  - From CPU_ACC: `hold_ack`=1 after edge N+1.
- **Release:** `hold` low sampled at edge M → `hold_ack`=0 after edge M.
- **Display read:** address presented in cycle k with `hold_ack`=1; data appears on `disp_data` in cycle k+1. The display pipelines addresses one cycle ahead.
- **CPU access:** request sampled in IDLE at edge N → CPU_ACC; `cpu_ready` pulses after edge N+1. Latency is 2 cycles; it is longer by the grant length if the display owns the bus.
- **Forced release:** with `hold` continuously high, `hold_ack` is high for exactly `MAX_HOLD` cycles, then 0. `hold_overrun`=1 from the same edge.

## Test plan
- **Reset values:** assert `rst_n`=0 mid-GRANT → `hold_ack` falls without a clock edge. All outputs read 0 after release.
- **Display burst:**
  - Preload RAM[0x055..0x059] = 0xAAAA, 0x1111, 0x2222, 0x3333, 0x4444.
  - Raise `hold` → `hold_ack` after 1 edge.
  - Step `disp_addr` 0x055..0x059 → `disp_data` shows each word one cycle later.
  - Drop `hold` → `hold_ack` low next edge.
- **Simultaneous requests:** `hold` and a `cpu_req` read of 0x010 rise together in IDLE → display granted first. `cpu_ready` pulses 2 cycles after `hold` drops, with RAM[0x010].
- **Hold during CPU write:** CPU write 0xBEEF to 0x020 is in CPU_ACC when `hold` rises → write completes and `cpu_ready`=1. `hold_ack` follows next edge. A display read of 0x020 returns 0xBEEF.
- **Overrun:** `MAX_HOLD`=8, `hold` held 20 cycles → `hold_ack` high exactly 8 cycles and `hold_overrun`=1. No re-grant until `hold` drops; a CPU read completes during the block. `hold` re-raised after the drop → granted again.
- **CPU back-to-back:** `cpu_req` held across 3 reads of 0x001..0x003 → `cpu_ready` pulses every 2 cycles with the correct data.
